// File: rtl/two_bit_output_seq_generator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : two_bit_output_seq_generator                                 |
// | Brief    : Serialises a fixed pattern, repeated 1..16 times, into 2-bit |
// |            symbols (earlier bit in data_out[1]) with optional lead pad. |
// | Revision : 1.0 - initial release                                        |
// ---------------------------------------------------------------------------
module two_bit_output_seq_generator #(
  parameter int              PAT_W    = 7,
  parameter logic [PAT_W-1:0] PATTERN = 7'b1011001,
  parameter logic            PAD_BIT  = 1'b0,
  parameter logic [1:0]      IDLE_SYM = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       offset,
  input  logic [3:0] repeat_cnt,
  output logic [1:0] data_out,
  output logic       data_valid,
  output logic       busy,
  output logic       done
);

  localparam int c_IDX_W = $clog2(PAT_W);
  localparam int c_CNT_W = $clog2(1 + PAT_W * 16 + 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_lead;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_CNT_W-1:0]   r_left;

  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_src_lead;
  logic [c_IDX_W-1:0]   w_src_idx;
  logic [c_CNT_W-1:0]   w_src_left;
  logic                 w_lead;
  logic [c_IDX_W-1:0]   w_idx;
  logic [c_CNT_W-1:0]   w_left;
  logic [1:0]           w_sym;
  logic                 w_lead_nxt;
  logic [c_IDX_W-1:0]   w_idx_nxt;
  logic [c_CNT_W-1:0]   w_left_nxt;
  logic [1:0]           w_data_nxt;
  logic                 w_valid_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;

  // An accepted start feeds the freshly latched stream description straight
  // into the symbol builder so the first symbol is registered on the accept edge.
  assign w_accept   = (r_state != ST_SEND) && start;
  assign w_src_lead = w_accept ? offset : r_lead;
  assign w_src_idx  = w_accept ? c_IDX_W'(PAT_W - 1) : r_idx;
  assign w_src_left = w_accept ? c_CNT_W'(PAT_W) * (c_CNT_W'(repeat_cnt) + c_CNT_W'(1))
                               : r_left;

  always_comb begin
    w_lead = w_src_lead;
    w_idx  = w_src_idx;
    w_left = w_src_left;
    w_sym  = IDLE_SYM;
    for (int b = 1; b >= 0; b--) begin
      if (w_lead) begin
        w_sym[b] = PAD_BIT;
        w_lead   = 1'b0;
      end else if (w_left != '0) begin
        w_sym[b] = PATTERN[w_idx];
        w_idx    = (w_idx == '0) ? c_IDX_W'(PAT_W - 1) : w_idx - c_IDX_W'(1);
        w_left   = w_left - c_CNT_W'(1);
      end else begin
        w_sym[b] = PAD_BIT;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lead_nxt  = r_lead;
    w_idx_nxt   = r_idx;
    w_left_nxt  = r_left;
    w_data_nxt  = IDLE_SYM;
    w_valid_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_SEND;
          w_lead_nxt  = w_lead;
          w_idx_nxt   = w_idx;
          w_left_nxt  = w_left;
          w_data_nxt  = w_sym;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!r_lead && (r_left == '0)) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_lead_nxt  = w_lead;
          w_idx_nxt   = w_idx;
          w_left_nxt  = w_left;
          w_data_nxt  = w_sym;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_lead     <= 1'b0;
      r_idx      <= '0;
      r_left     <= '0;
      data_out   <= IDLE_SYM;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lead     <= w_lead_nxt;
      r_idx      <= w_idx_nxt;
      r_left     <= w_left_nxt;
      data_out   <= w_data_nxt;
      data_valid <= w_valid_nxt;
      busy       <= w_busy_nxt;
      done       <= w_done_nxt;
    end
  end

endmodule
`default_nettype wire
